// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Indexed [row][col]; '*' reads as E and '#' as F.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    if (!r[0])      idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to a chosen idle level.
module sync_2ff #(
  parameter int           W    = 1,
  parameter logic [W-1:0] IDLE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= IDLE;
      q    <= IDLE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, two-deep digit history.
// state       | meaning
// SCAN        | drive columns in turn, sample rows on the last dwell cycle
// DEB_PRESS   | column frozen, count stable-low samples of the latched row
// HELD        | key accepted, wait for the latched row to go high
// DEB_RELEASE | count stable-high samples before resuming the scan
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] PRESS_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] REL_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    rows_s;
  state_t        state, state_nx;
  logic [1:0]    col_idx, col_nx;
  logic [1:0]    row_lat, row_nx;
  logic [DW-1:0] dwell, dwell_nx;
  logic [CW-1:0] deb_cnt, deb_nx;
  logic          commit;
  logic          row_high;

  sync_2ff #(.W(4), .IDLE(4'hF)) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign row_high = rows_s[row_lat];
  assign cols     = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_lat   <= 2'd0;
      dwell     <= '0;
      deb_cnt   <= '0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      col_idx   <= col_nx;
      row_lat   <= row_nx;
      dwell     <= dwell_nx;
      deb_cnt   <= deb_nx;
      key_valid <= commit;
      if (commit) begin
        digit_old <= digit_new;
        digit_new <= KEYMAP[row_lat][col_idx];
      end
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = col_idx;
    row_nx   = row_lat;
    dwell_nx = dwell;
    deb_nx   = deb_cnt;
    commit   = 1'b0;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nx = '0;
          if (rows_s != 4'hF) begin
            row_nx   = lowest_low(rows_s);
            deb_nx   = '0;
            state_nx = DEB_PRESS;
          end else begin
            col_nx = col_idx + 2'd1;
          end
        end else begin
          dwell_nx = dwell + 1'b1;
        end
      end
      DEB_PRESS: begin
        // dwell was cleared on leaving SCAN, so a bounce restarts the same column
        if (row_high) begin
          state_nx = SCAN;
        end else if (deb_cnt == PRESS_LAST) begin
          commit   = 1'b1;
          state_nx = HELD;
        end else begin
          deb_nx = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (row_high) begin
          deb_nx   = '0;
          state_nx = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (!row_high) begin
          state_nx = HELD;
        end else if (deb_cnt == REL_LAST) begin
          state_nx = SCAN;
        end else begin
          deb_nx = deb_cnt + 1'b1;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a resistive-matrix keypad model.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  digit_new;
  logic [3:0]  digit_old;
  logic        key_valid;
  logic [15:0] pressed;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int consec = 0;
  logic kv_prev = 1'b0;

  always #5 clk = ~clk;

  // A pressed key at [r][c] pulls row r low whenever column c is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .key_valid (key_valid)
  );

  always @(negedge clk) begin
    if (key_valid) begin
      pulses = pulses + 1;
      if (kv_prev) consec = consec + 1;
    end
    kv_prev = key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_kv(input int budget, input string tag);
    int n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, key_valid, 1);
  endtask

  task automatic wait_cols(input logic [3:0] val, input logic want_eq, input string tag);
    int n = 0;
    while (((cols == val) != want_eq) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (cols == val), want_eq);
  endtask

  initial begin
    int p0;
    logic [3:0] one;
    logic [3:0] exp_c;
    one     = 4'b0001;
    pressed = '0;
    reset   = 1'b1;

    // 1: reset values and free-running scan order
    step(3);
    chk("rst_cols", cols, 4'b1110);
    chk("rst_new", digit_new, 4'h0);
    chk("rst_old", digit_old, 4'h0);
    chk("rst_kv", key_valid, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      exp_c = ~(one << ((k / 4) % 4));
      chk("scan_seq", cols, exp_c);
    end
    @(negedge clk);

    // 2: key 6 then key 0
    p0 = pulses;
    pressed[1*4+2] = 1'b1;
    wait_kv(30, "k6");
    chk("k6_new", digit_new, 4'h6);
    chk("k6_old", digit_old, 4'h0);
    step(40);
    pressed = '0;
    step(40);
    pressed[3*4+1] = 1'b1;
    wait_kv(30, "k0");
    chk("k0_new", digit_new, 4'h0);
    chk("k0_old", digit_old, 4'h6);
    step(20);
    pressed = '0;
    step(40);
    chk("t2_pulses", pulses - p0, 2);

    // 3: bounce on press of key 1
    p0 = pulses;
    pressed[0] = 1'b1;
    step(3);
    pressed[0] = 1'b0;
    step(2);
    chk("t3_glitch", pulses - p0, 0);
    pressed[0] = 1'b1;
    wait_kv(45, "k1");
    chk("k1_new", digit_new, 4'h1);
    chk("k1_old", digit_old, 4'h0);
    step(30);
    pressed = '0;
    step(40);
    chk("t3_pulses", pulses - p0, 1);

    // 4: bounce on release of key A
    p0 = pulses;
    pressed[3] = 1'b1;
    wait_kv(30, "kA");
    chk("kA_new", digit_new, 4'hA);
    chk("kA_old", digit_old, 4'h1);
    step(10);
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) pressed[3] = ~pressed[3];
      step(1);
    end
    pressed[3] = 1'b0;
    step(5);
    chk("t4_frozen", cols, 4'b0111);
    wait_cols(4'b0111, 1'b0, "t4_resume");
    step(20);
    chk("t4_pulses", pulses - p0, 1);
    chk("t4_new", digit_new, 4'hA);

    // 5: key 9 pressed while key 5 held
    p0 = pulses;
    pressed[1*4+1] = 1'b1;
    wait_kv(30, "k5");
    chk("k5_new", digit_new, 4'h5);
    chk("k5_old", digit_old, 4'hA);
    step(1);
    pressed[2*4+2] = 1'b1;
    step(40);
    chk("t5_both", pulses - p0, 1);
    pressed[1*4+1] = 1'b0;
    step(10);
    chk("t5_early", pulses - p0, 1);
    wait_kv(40, "k9");
    chk("k9_new", digit_new, 4'h9);
    chk("k9_old", digit_old, 4'h5);
    step(1);
    pressed = '0;
    step(40);
    chk("t5_pulses", pulses - p0, 2);

    // two rows low in one column: lowest row index wins
    pressed[0*4+1] = 1'b1;
    pressed[2*4+1] = 1'b1;
    wait_kv(30, "k2");
    chk("k2_new", digit_new, 4'h2);
    chk("k2_old", digit_old, 4'h9);
    step(1);
    pressed = '0;
    step(40);

    // 6: reset in the middle of debouncing key C
    p0 = pulses;
    pressed[2*4+3] = 1'b1;
    wait_cols(4'b0111, 1'b0, "t6_off_col3");
    wait_cols(4'b0111, 1'b1, "t6_on_col3");
    step(6);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_cols", cols, 4'b1110);
    chk("t6_rst_new", digit_new, 4'h0);
    chk("t6_rst_old", digit_old, 4'h0);
    chk("t6_rst_kv", key_valid, 1'b0);
    pressed = '0;
    step(2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_col0", cols, 4'b1110);
    step(30);
    chk("t6_pulses", pulses - p0, 0);
    chk("t6_new", digit_new, 4'h0);

    chk("kv_single", consec, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
